// File: rtl/play_sequencer.sv
// Playback controller: walks the Song ROM note by note, hands each note to the
// Sound engine with a start/done handshake, inserts a muted articulation gap
// between notes and executes play/pause/stop/next/prev commands.
module play_sequencer #(
    parameter int SONG_BITS  = 3,
    parameter int NUM_SONGS  = 5,
    parameter int CNT_BITS   = 8,
    parameter int GAP_CYCLES = 2000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [SONG_BITS-1:0] song_sel,
    input  logic                 cmd_play,
    input  logic                 cmd_pause,
    input  logic                 cmd_stop,
    input  logic                 cmd_next,
    input  logic                 cmd_prev,
    input  logic                 loop_all,
    input  logic [CNT_BITS-1:0]  track_last,
    input  logic                 note_done,
    output logic [SONG_BITS-1:0] song_idx,
    output logic [CNT_BITS-1:0]  note_idx,
    output logic                 note_start,
    output logic                 sound_abort,
    output logic                 mute,
    output logic                 playing,
    output logic                 paused,
    output logic                 song_end
);

    // Gap counter only has to hold GAP_CYCLES-1.
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0]     GAP_LOAD  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [SONG_BITS-1:0] LAST_SONG = SONG_BITS'(NUM_SONGS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_PLAY,
        S_GAP,
        S_PAUSED
    } state_t;

    typedef enum logic [2:0] {
        C_NONE,
        C_STOP,
        C_PREV,
        C_NEXT,
        C_PAUSE,
        C_PLAY
    } cmd_t;

    state_t           state;
    cmd_t             cmd;
    logic [GAP_W-1:0] gap_cnt;

    // Next song index, wrapping after the last song in the ROM.
    function automatic logic [SONG_BITS-1:0] song_inc(input logic [SONG_BITS-1:0] s);
        return (s >= LAST_SONG) ? '0 : s + SONG_BITS'(1);
    endfunction

    // Previous song index, wrapping from song 0 to the last song.
    function automatic logic [SONG_BITS-1:0] song_dec(input logic [SONG_BITS-1:0] s);
        return (s == '0 || s > LAST_SONG) ? LAST_SONG : s - SONG_BITS'(1);
    endfunction

    // Out-of-range song selections fall back to song 0.
    function automatic logic [SONG_BITS-1:0] song_clamp(input logic [SONG_BITS-1:0] s);
        return (s > LAST_SONG) ? '0 : s;
    endfunction

    // Status flags {mute, playing, paused} that hold while in a given state.
    function automatic logic [2:0] flags_for(input state_t s);
        case (s)
            S_FETCH, S_PLAY: return 3'b010;
            S_GAP:           return 3'b110;
            S_PAUSED:        return 3'b101;
            default:         return 3'b100;
        endcase
    endfunction

    // Resolve simultaneous commands to the single highest-priority one; losing
    // auto mode behaves exactly like a stop.
    always_comb begin
        cmd = C_NONE;
        if (!en)            cmd = C_STOP;
        else if (cmd_stop)  cmd = C_STOP;
        else if (cmd_prev)  cmd = C_PREV;
        else if (cmd_next)  cmd = C_NEXT;
        else if (cmd_pause) cmd = C_PAUSE;
        else if (cmd_play)  cmd = C_PLAY;
    end

    // Playback FSM with registered indices, status flags and one-cycle pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            song_idx    <= '0;
            note_idx    <= '0;
            gap_cnt     <= '0;
            note_start  <= 1'b0;
            sound_abort <= 1'b0;
            song_end    <= 1'b0;
            mute        <= 1'b1;
            playing     <= 1'b0;
            paused      <= 1'b0;
        end else begin
            note_start  <= 1'b0;
            sound_abort <= 1'b0;
            song_end    <= 1'b0;

            if (state == S_IDLE) begin
                if (cmd == C_PLAY) begin
                    song_idx                <= song_clamp(song_sel);
                    note_idx                <= '0;
                    state                   <= S_FETCH;
                    {mute, playing, paused} <= flags_for(S_FETCH);
                end
            end else if (cmd == C_STOP) begin
                sound_abort             <= (state == S_PLAY);
                note_idx                <= '0;
                state                   <= S_IDLE;
                {mute, playing, paused} <= flags_for(S_IDLE);
            end else if (cmd == C_PREV || cmd == C_NEXT) begin
                // Both restart playback at note 0; prev only changes song when
                // already at the first note.
                sound_abort <= (state == S_PLAY);
                if (cmd == C_NEXT)
                    song_idx <= song_inc(song_idx);
                else if (note_idx == '0)
                    song_idx <= song_dec(song_idx);
                note_idx                <= '0;
                state                   <= S_FETCH;
                {mute, playing, paused} <= flags_for(S_FETCH);
            end else if (cmd == C_PAUSE && state != S_PAUSED) begin
                sound_abort             <= (state == S_PLAY);
                state                   <= S_PAUSED;
                {mute, playing, paused} <= flags_for(S_PAUSED);
            end else if (cmd == C_PLAY && state == S_PAUSED) begin
                // Resume re-fetches the held note so it replays from its start.
                state                   <= S_FETCH;
                {mute, playing, paused} <= flags_for(S_FETCH);
            end else begin
                case (state)
                    S_FETCH: begin
                        note_start              <= 1'b1;
                        state                   <= S_PLAY;
                        {mute, playing, paused} <= flags_for(S_PLAY);
                    end
                    S_PLAY: begin
                        if (note_done) begin
                            gap_cnt                 <= GAP_LOAD;
                            state                   <= S_GAP;
                            {mute, playing, paused} <= flags_for(S_GAP);
                        end
                    end
                    S_GAP: begin
                        if (gap_cnt != '0) begin
                            gap_cnt <= gap_cnt - GAP_W'(1);
                        end else if (note_idx < track_last) begin
                            note_idx                <= note_idx + CNT_BITS'(1);
                            state                   <= S_FETCH;
                            {mute, playing, paused} <= flags_for(S_FETCH);
                        end else begin
                            song_end <= 1'b1;
                            note_idx <= '0;
                            if (loop_all) begin
                                song_idx                <= song_inc(song_idx);
                                state                   <= S_FETCH;
                                {mute, playing, paused} <= flags_for(S_FETCH);
                            end else begin
                                state                   <= S_IDLE;
                                {mute, playing, paused} <= flags_for(S_IDLE);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_play_sequencer.sv
// Self-checking bench for play_sequencer: directed scenarios plus randomized
// command/note_done traffic, compared every cycle against a behavioural model.
module tb_play_sequencer;

    localparam int SB  = 3;
    localparam int NS  = 5;
    localparam int CB  = 8;
    localparam int GAP = 4;

    localparam int M_IDLE   = 0;
    localparam int M_FETCH  = 1;
    localparam int M_PLAY   = 2;
    localparam int M_GAP    = 3;
    localparam int M_PAUSED = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [SB-1:0] song_sel;
    logic          cmd_play, cmd_pause, cmd_stop, cmd_next, cmd_prev;
    logic          loop_all;
    logic [CB-1:0] track_last;
    logic          note_done;
    logic [SB-1:0] song_idx;
    logic [CB-1:0] note_idx;
    logic          note_start, sound_abort, mute, playing, paused, song_end;

    // Song ROM stand-in: index of the last note of each song.
    int rom_last [NS] = '{6, 0, 2, 5, 1};

    int total_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;

    // Behavioural model state
    int m_mode, m_song, m_note, m_gap_left;
    int e_start, e_abort, e_end;

    play_sequencer #(
        .SONG_BITS (SB),
        .NUM_SONGS (NS),
        .CNT_BITS  (CB),
        .GAP_CYCLES(GAP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .song_sel   (song_sel),
        .cmd_play   (cmd_play),
        .cmd_pause  (cmd_pause),
        .cmd_stop   (cmd_stop),
        .cmd_next   (cmd_next),
        .cmd_prev   (cmd_prev),
        .loop_all   (loop_all),
        .track_last (track_last),
        .note_done  (note_done),
        .song_idx   (song_idx),
        .note_idx   (note_idx),
        .note_start (note_start),
        .sound_abort(sound_abort),
        .mute       (mute),
        .playing    (playing),
        .paused     (paused),
        .song_end   (song_end)
    );

    always #5 clk = ~clk;

    // ROM lookup driven by the address the DUT presents
    always_comb begin
        int idx;
        idx = int'(song_idx);
        track_last = (idx < NS) ? CB'(rom_last[idx]) : '0;
    end

    task automatic finish_run();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
            if (fail_cnt >= 40) finish_run();
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_song = 0; m_note = 0; m_gap_left = 0;
        e_start = 0; e_abort = 0; e_end = 0;
    endtask

    // Apply one clock of the playback rules to the model, from the inputs
    // currently on the pins. Command codes: 1 stop 2 prev 3 next 4 pause 5 play.
    task automatic model_step();
        int w;
        e_start = 0; e_abort = 0; e_end = 0;
        if (!en || cmd_stop) w = 1;
        else if (cmd_prev)   w = 2;
        else if (cmd_next)   w = 3;
        else if (cmd_pause)  w = 4;
        else if (cmd_play)   w = 5;
        else                 w = 0;

        if (m_mode == M_IDLE) begin
            if (w == 5) begin
                m_song = (int'(song_sel) < NS) ? int'(song_sel) : 0;
                m_note = 0;
                m_mode = M_FETCH;
            end
            return;
        end
        if (w == 1) begin
            e_abort = (m_mode == M_PLAY);
            m_mode = M_IDLE;
            m_note = 0;
            return;
        end
        if (w == 2 || w == 3) begin
            e_abort = (m_mode == M_PLAY);
            if (w == 3) m_song = (m_song + 1) % NS;
            else if (m_note == 0) m_song = (m_song + NS - 1) % NS;
            m_note = 0;
            m_mode = M_FETCH;
            return;
        end
        if (w == 4 && m_mode != M_PAUSED) begin
            e_abort = (m_mode == M_PLAY);
            m_mode = M_PAUSED;
            return;
        end
        if (w == 5 && m_mode == M_PAUSED) begin
            m_mode = M_FETCH;
            return;
        end
        case (m_mode)
            M_FETCH: begin
                e_start = 1;
                m_mode = M_PLAY;
            end
            M_PLAY: if (note_done) begin
                m_gap_left = GAP;
                m_mode = M_GAP;
            end
            M_GAP: begin
                m_gap_left--;
                if (m_gap_left == 0) begin
                    if (m_note < rom_last[m_song]) begin
                        m_note++;
                        m_mode = M_FETCH;
                    end else begin
                        e_end = 1;
                        m_note = 0;
                        if (loop_all) begin
                            m_song = (m_song + 1) % NS;
                            m_mode = M_FETCH;
                        end else begin
                            m_mode = M_IDLE;
                        end
                    end
                end
            end
            default: ;
        endcase
    endtask

    task automatic compare_all();
        chk("song_idx",    int'(song_idx),    m_song);
        chk("note_idx",    int'(note_idx),    m_note);
        chk("note_start",  int'(note_start),  e_start);
        chk("sound_abort", int'(sound_abort), e_abort);
        chk("song_end",    int'(song_end),    e_end);
        chk("mute",        int'(mute),        int'(m_mode == M_IDLE || m_mode == M_GAP || m_mode == M_PAUSED));
        chk("playing",     int'(playing),     int'(m_mode == M_FETCH || m_mode == M_PLAY || m_mode == M_GAP));
        chk("paused",      int'(paused),      int'(m_mode == M_PAUSED));
    endtask

    // One clock: model advances with the current inputs, DUT is compared at the
    // next falling edge, then single-cycle pulses are dropped.
    task automatic tick();
        model_step();
        @(negedge clk);
        compare_all();
        cmd_play = 0; cmd_pause = 0; cmd_stop = 0; cmd_next = 0; cmd_prev = 0;
        note_done = 0;
    endtask

    task automatic run_until_start(output int ticks, output int muted, output int ends);
        ticks = 0; muted = 0; ends = 0;
        do begin
            tick();
            ticks++;
            if (mute) muted++;
            if (song_end) ends++;
        end while (!note_start && ticks < 40);
        if (!note_start) chk("timeout_note_start", 0, 1);
    endtask

    task automatic note_cycle();
        repeat (2) tick();
        note_done = 1;
        tick();
    endtask

    task automatic stop_now();
        cmd_stop = 1;
        tick();
        tick();
    endtask

    task automatic play_to_note(input int song, input int n);
        int t, m, e;
        song_sel = SB'(song);
        cmd_play = 1;
        run_until_start(t, m, e);
        for (int k = 0; k < n; k++) begin
            note_cycle();
            run_until_start(t, m, e);
        end
    endtask

    initial begin
        int t, m, e, mute_at_done, starts;
        rst_n = 0; en = 1; song_sel = '0; loop_all = 0; note_done = 0;
        cmd_play = 0; cmd_pause = 0; cmd_stop = 0; cmd_next = 0; cmd_prev = 0;
        model_reset();
        @(negedge clk);
        compare_all();
        chk("reset_mute", int'(mute), 1);
        @(negedge clk);
        rst_n = 1;

        // Three-note song played to completion without looping
        song_sel = 3'd2;
        cmd_play = 1;
        run_until_start(t, m, e);
        chk("play_to_start_latency", t, 2);
        for (int k = 0; k < 3; k++) begin
            chk("t2_note_idx", int'(note_idx), k);
            chk("t2_song_idx", int'(song_idx), 2);
            repeat (9) tick();
            note_done = 1;
            tick();
            mute_at_done = int'(mute);
            if (k < 2) begin
                run_until_start(t, m, e);
                chk("t2_gap_muted_cycles", mute_at_done + m, GAP);
                chk("t2_no_early_song_end", e, 0);
            end else begin
                t = 0; e = 0; starts = 0;
                do begin
                    tick();
                    t++;
                    if (song_end) e++;
                    if (note_start) starts++;
                end while (playing && t < 40);
                chk("t2_song_end_count", e, 1);
                chk("t2_final_playing", int'(playing), 0);
                chk("t2_final_note_idx", int'(note_idx), 0);
                chk("t2_final_mute", int'(mute), 1);
                chk("t2_no_extra_start", starts, 0);
            end
        end

        // Loop from the last song wraps to song 0
        loop_all = 1;
        play_to_note(4, 1);
        note_cycle();
        t = 0;
        do begin
            tick();
            t++;
        end while (!song_end && t < 40);
        chk("t3_song_end", int'(song_end), 1);
        chk("t3_wrap_song", int'(song_idx), 0);
        chk("t3_wrap_note", int'(note_idx), 0);
        loop_all = 0;
        stop_now();

        // Pause mid-note, then resume the same note
        play_to_note(0, 3);
        chk("t4_note_before_pause", int'(note_idx), 3);
        cmd_pause = 1;
        tick();
        chk("t4_abort", int'(sound_abort), 1);
        chk("t4_paused", int'(paused), 1);
        chk("t4_mute", int'(mute), 1);
        repeat (3) tick();
        cmd_play = 1;
        run_until_start(t, m, e);
        chk("t4_resume_latency", t, 2);
        chk("t4_resume_note", int'(note_idx), 3);
        stop_now();

        // prev restarts the song, then steps back to the previous song
        play_to_note(3, 5);
        cmd_prev = 1;
        tick();
        chk("t5_prev_note", int'(note_idx), 0);
        chk("t5_prev_same_song", int'(song_idx), 3);
        chk("t5_prev_abort", int'(sound_abort), 1);
        run_until_start(t, m, e);
        stop_now();
        play_to_note(0, 0);
        cmd_prev = 1;
        tick();
        chk("t5_prev_wrap_song", int'(song_idx), 4);
        chk("t5_prev_wrap_note", int'(note_idx), 0);
        stop_now();

        // next beats a same-cycle note_done
        play_to_note(1, 0);
        tick();
        cmd_next = 1;
        note_done = 1;
        tick();
        chk("t6_next_song", int'(song_idx), 2);
        chk("t6_next_note", int'(note_idx), 0);
        chk("t6_not_muted", int'(mute), 0);
        chk("t6_abort", int'(sound_abort), 1);
        tick();
        chk("t6_start_without_gap", int'(note_start), 1);
        stop_now();

        // Asynchronous reset in the middle of a note
        play_to_note(2, 1);
        tick();
        rst_n = 0;
        #1;
        model_reset();
        compare_all();
        chk("t1_reset_mute", int'(mute), 1);
        chk("t1_reset_note", int'(note_idx), 0);
        chk("t1_reset_song", int'(song_idx), 0);
        @(negedge clk);
        compare_all();
        rst_n = 1;
        starts = 0;
        repeat (4) begin
            tick();
            if (note_start) starts++;
        end
        chk("t1_no_start_after_reset", starts, 0);

        // Randomized traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int r;
            if (cyc % 200 == 0) loop_all = 1'($urandom_range(0, 1));
            en        = ($urandom_range(0, 99) != 0);
            note_done = ($urandom_range(0, 7) == 0);
            song_sel  = SB'($urandom_range(0, 7));
            r = $urandom_range(0, 99);
            if (r < 4)       cmd_play  = 1;
            else if (r < 6)  cmd_pause = 1;
            else if (r < 7)  cmd_stop  = 1;
            else if (r < 9)  cmd_next  = 1;
            else if (r < 11) cmd_prev  = 1;
            else if (r < 13 && (m_mode == M_FETCH || m_mode == M_PLAY || m_mode == M_GAP)) begin
                cmd_stop  = 1'($urandom_range(0, 1));
                cmd_prev  = 1'($urandom_range(0, 1));
                cmd_next  = 1'($urandom_range(0, 1));
                cmd_pause = 1'($urandom_range(0, 1));
                cmd_play  = 1'($urandom_range(0, 1));
            end
            tick();
        end

        finish_run();
    end

endmodule
